// File: rtl/button_event_controller.sv
// button_event_controller: debounced short/long press classifier feeding a fixed-priority event FIFO
module button_event_controller #(
   parameter int NUM_BUTTONS     = 4,
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int LONG_CYCLES     = 2000000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] buttons_n,
   output logic [NUM_BUTTONS-1:0] press_pulse,
   output logic                   event_valid,
   output logic [3:0]             event_data,
   input  logic                   event_ready,
   output logic                   overflow
);
   localparam int MAXC = DEBOUNCE_CYCLES > LONG_CYCLES ? DEBOUNCE_CYCLES : LONG_CYCLES;
   localparam int CW = $clog2(MAXC) + 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = AW + 1;
   localparam logic [CW-1:0] REL_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_CYCLES - 2);
   typedef enum logic [1:0] {WAIT_REL, ARMED, HELD} state_t;

   logic [NUM_BUTTONS-1:0] raise, rtype, pulse, pending, ptype, clr, accept;
   logic [3:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [NW-1:0] count;
   logic [2:0] sel;
   logic sel_type, push, pop;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      state_t state, state_d;
      logic [CW-1:0] rel_cnt, rel_d, hold_cnt, hold_d;
      logic pressed, raise_d, long_d, pulse_d;
      assign pressed = ~buttons_n[i];
      always_ff @(posedge clk)
         if (reset) begin
            state    <= WAIT_REL;
            rel_cnt  <= '0;
            hold_cnt <= '0;
         end else begin
            state    <= state_d;
            rel_cnt  <= rel_d;
            hold_cnt <= hold_d;
         end
      // the long threshold fires on the LONG_CYCLES-th pressed sample, when hold_cnt would become LONG_CYCLES-1
      always_comb begin
         state_d = state;
         rel_d   = rel_cnt;
         hold_d  = hold_cnt;
         raise_d = 1'b0;
         long_d  = 1'b0;
         pulse_d = 1'b0;
         case (state)
            WAIT_REL: begin
               rel_d = pressed ? '0 : (rel_cnt == '1 ? rel_cnt : rel_cnt + CW'(1));
               if (!pressed && rel_cnt == REL_LAST) state_d = ARMED;
            end
            ARMED: if (pressed) begin
               state_d = HELD;
               hold_d  = '0;
               pulse_d = 1'b1;
            end
            HELD: if (!pressed) begin
               state_d = WAIT_REL;
               rel_d   = CW'(1);
               raise_d = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_d = WAIT_REL;
               rel_d   = '0;
               raise_d = 1'b1;
               long_d  = 1'b1;
            end else begin
               hold_d = hold_cnt == '1 ? hold_cnt : hold_cnt + CW'(1);
            end
            default: state_d = WAIT_REL;
         endcase
      end
      assign raise[i] = raise_d;
      assign rtype[i] = long_d;
      assign pulse[i] = pulse_d;
   end

   always_comb begin
      sel      = '0;
      sel_type = 1'b0;
      for (int k = NUM_BUTTONS - 1; k >= 0; k--)
         if (pending[k]) begin
            sel      = 3'(k);
            sel_type = ptype[k];
         end
      pop    = event_valid && event_ready;
      push   = |pending && (count != NW'(FIFO_DEPTH) || pop);
      clr    = push ? NUM_BUTTONS'(1) << sel : '0;
      accept = raise & ~pending;
   end

   always_ff @(posedge clk)
      if (reset) begin
         pending     <= '0;
         ptype       <= '0;
         press_pulse <= '0;
         overflow    <= 1'b0;
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
      end else begin
         pending     <= (pending & ~clr) | accept;
         ptype       <= (ptype & ~accept) | (rtype & accept);
         press_pulse <= pulse;
         overflow    <= overflow | (|(raise & pending));
         if (push) wptr <= wptr + AW'(1);
         if (pop) rptr <= rptr + AW'(1);
         count       <= count + NW'(push) - NW'(pop);
      end

   always_ff @(posedge clk)
      if (push) mem[wptr] <= {sel_type, sel};

   assign event_valid = count != '0;
   assign event_data  = event_valid ? mem[rptr] : 4'd0;
endmodule

// File: tb/tb_button_event_controller.sv
// tb_button_event_controller: directed and random stimulus against a behavioural press/queue model
module tb_button_event_controller;
   localparam int NB = 4, DEB = 8, LONG = 32, DEPTH = 4;
   logic clk = 1'b0, reset = 1'b1, event_ready = 1'b0;
   logic event_valid, overflow;
   logic [NB-1:0] buttons_n, press_pulse;
   logic [NB-1:0] btn = '0;
   logic [3:0] event_data;
   int total = 0, bad = 0;
   int quiet[NB], plen[NB], dur[NB];
   bit pend[NB], ptyp[NB], m_ovf;
   logic [NB-1:0] m_pulse = '0;
   logic [3:0] q[$];

   assign buttons_n = ~btn;
   always #5 clk = ~clk;

   button_event_controller #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .buttons_n(buttons_n), .press_pulse(press_pulse),
      .event_valid(event_valid), .event_data(event_data), .event_ready(event_ready), .overflow(overflow));

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // a button is armed once it has seen DEB released samples since its last press ended
   task automatic model_edge();
      bit snap[NB];
      bit popq, r, l;
      int k;
      m_pulse = '0;
      if (reset) begin
         for (int i = 0; i < NB; i++) begin
            quiet[i] = 0; plen[i] = 0; pend[i] = 0; ptyp[i] = 0;
         end
         q.delete();
         m_ovf = 0;
         return;
      end
      snap = pend;
      popq = q.size() > 0 && event_ready;
      k = -1;
      for (int i = 0; i < NB; i++) if (snap[i]) begin k = i; break; end
      if (k >= 0 && (q.size() < DEPTH || popq)) begin
         if (popq) void'(q.pop_front());
         q.push_back({ptyp[k], 3'(k)});
         pend[k] = 0;
      end else if (popq) void'(q.pop_front());
      for (int i = 0; i < NB; i++) begin
         r = 0; l = 0;
         if (plen[i] > 0) begin
            if (btn[i]) begin
               plen[i]++;
               if (plen[i] == LONG) begin r = 1; l = 1; plen[i] = 0; quiet[i] = 0; end
            end else begin
               r = 1; plen[i] = 0; quiet[i] = 1;
            end
         end else if (quiet[i] >= DEB) begin
            if (btn[i]) begin plen[i] = 1; m_pulse[i] = 1'b1; end
         end else quiet[i] = btn[i] ? 0 : quiet[i] + 1;
         if (r) begin
            if (snap[i]) m_ovf = 1;
            else begin pend[i] = 1; ptyp[i] = l; end
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check("pulse", press_pulse, m_pulse);
      check("valid", event_valid, q.size() > 0);
      check("data", event_data, q.size() > 0 ? q[0] : 4'd0);
      check("ovf", overflow, m_ovf);
   endtask

   task automatic hold(input logic [NB-1:0] mask, input int n);
      btn = mask;
      repeat (n) step();
   endtask

   initial begin
      step(); step();
      reset = 1'b0;
      check("rst_valid", event_valid, 1'b0);
      check("rst_data", event_data, 4'd0);
      hold(4'b0000, 8); hold(4'b0001, 5); hold(4'b0000, 3);
      event_ready = 1'b1; hold(4'b0000, 2); event_ready = 1'b0;
      hold(4'b0000, 8); hold(4'b0100, 40); hold(4'b0000, 3); hold(4'b0100, 2); hold(4'b0000, 3);
      event_ready = 1'b1; hold(4'b0000, 3); event_ready = 1'b0;
      hold(4'b0000, 10); hold(4'b0010, 3); hold(4'b0000, 2); hold(4'b0010, 3); hold(4'b0000, 10);
      event_ready = 1'b1; hold(4'b0000, 3); event_ready = 1'b0;
      hold(4'b0000, 10); hold(4'b1011, 3); hold(4'b0000, 6);
      event_ready = 1'b1; hold(4'b0000, 5); event_ready = 1'b0;
      repeat (6) begin hold(4'b0000, 10); hold(4'b0001, 3); end
      hold(4'b0000, 10);
      check("t5_ovf", overflow, 1'b1);
      check("t5_valid", event_valid, 1'b1);
      event_ready = 1'b1; hold(4'b0000, 8); event_ready = 1'b0;
      hold(4'b0001, 2); hold(4'b0000, 10); hold(4'b0010, 2); hold(4'b0000, 10); hold(4'b0001, 3);
      reset = 1'b1; step(); reset = 1'b0;
      check("t6_valid", event_valid, 1'b0);
      check("t6_ovf", overflow, 1'b0);
      hold(4'b0000, 12);
      for (int i = 0; i < NB; i++) dur[i] = $urandom_range(1, 20);
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NB; i++)
            if (dur[i] == 0) begin
               btn[i] = ~btn[i];
               case ($urandom_range(0, 2))
                  0: dur[i] = $urandom_range(1, 4);
                  1: dur[i] = $urandom_range(5, 20);
                  default: dur[i] = $urandom_range(25, 45);
               endcase
            end else dur[i]--;
         event_ready = (c % 800) < 300 ? 1'b0 : ($urandom_range(0, 3) != 0);
         reset = $urandom_range(0, 1499) == 0;
         step();
      end
      reset = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/button_event_controller.md
Name: button_event_controller

Overview:
- Front-end controller for all front-panel push buttons.
- Debounces NUM_BUTTONS active-low buttons with a release lockout and classifies each press as short or long.
- Arbitrates simultaneous events by fixed priority into a small event FIFO.
- Downstream mode/menu logic pops the FIFO with a valid/ready handshake. Also emits a one-cycle per-button press pulse for legacy consumers.

Parameters:
- NUM_BUTTONS, 4, number of buttons (1..8).
- DEBOUNCE_CYCLES, 10000, continuous released cycles needed before a button re-arms.
- LONG_CYCLES, 2000000, held cycles at or above which a press is classified long.
- FIFO_DEPTH, 4, event FIFO entries (power of two, 2..16).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- buttons_n  in  NUM_BUTTONS  raw buttons, active low (0 = pressed), already synchronised.
- press_pulse  out  NUM_BUTTONS  one-cycle high on recognised press edge, per button.
- event_valid  out  1  FIFO non-empty.
- event_data  out  4  head event: [3] = 1 long / 0 short, [2:0] = button index.
- event_ready  in  1  consumer pops the head when valid && ready.
- overflow  out  1  sticky; set when any event is dropped.

Behaviour:
- Reset: all per-button FSMs go to WAIT_REL with counters 0 and pending cleared. FIFO empty. press_pulse = 0, event_valid = 0, event_data = 0, overflow = 0. A reset mid-press discards all in-flight and queued events.
- Per-button FSM:
  - WAIT_REL: rel_cnt increments while released and clears on any pressed sample. When rel_cnt == DEBOUNCE_CYCLES-1 on a released sample, go to ARMED. Power-up with a button held stays here.
  - ARMED: on a pressed sample, go to HELD, clear hold_cnt, and pulse press_pulse[i] the next cycle.
  - HELD: hold_cnt increments while pressed.
    - If hold_cnt reaches LONG_CYCLES-1 while still pressed: raise a long event and go to WAIT_REL. No further event until release plus lockout.
    - If a released sample arrives first: raise a short event and go to WAIT_REL with rel_cnt = 1.
  - Bounce inside HELD ends the press. The lockout in WAIT_REL prevents a second event.
- Event raise: sets pending[i] and ptype[i] on the same edge as the FSM transition. If pending[i] is already set, the new event is dropped, overflow is set, and the FSM transitions normally.
- Arbiter: each cycle it selects the lowest-index set pending bit.
  - Push is allowed when the FIFO is not full, or is full and a pop occurs this cycle.
  - On push, {ptype, index} is written and that pending bit is cleared on the same edge. At most one push per cycle. Higher indices wait.
- FIFO:
  - First-word-fall-through. event_data is valid whenever event_valid = 1, holds stable while not popped, and reads 0 when empty.
  - Pop when event_valid && event_ready. Simultaneous push and pop keeps the count unchanged. A pop when empty is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Latency, idle system:
  - Release sampled at edge t: pending set at t, pushed at t+1, event_valid high from t+1.
  - Long threshold hit at edge t: event_valid high from t+1.
- Counters: saturate, never wrap. Width = clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)) + 1.
- overflow: clears only on reset.

Test Plan (DEBOUNCE_CYCLES=8, LONG_CYCLES=32, FIFO_DEPTH=4):
1. Hold button 0 released for 8 cycles, press for 5, release -> press_pulse[0] high one cycle after press. event_valid rises 1 cycle after release edge with event_data=4'b0000. Pop with ready=1 -> valid low next cycle.
2. Press button 2 for 40 cycles -> event_data=4'b1010 valid 1 cycle after hold_cnt hits 31. No second event on release. A re-press within 7 released cycles is ignored.
3. Bounce button 1 (press 3 cycles, release 2, press 3, release) after arming -> exactly one short event 4'b0001. The second press gives no press_pulse until 8 clean released cycles.
4. Release buttons 3, 1, 0 on the same edge -> FIFO receives 4'b0000, 4'b0001, 4'b0011 on consecutive cycles, in that order.
5. Hold event_ready=0 and generate 6 short events on one button (re-arming each time) -> 4 queued, 1 pending, 6th dropped, overflow=1. Popping all returns 5 events in order.
6. Assert reset with 2 events queued and button 0 in HELD -> next cycle event_valid=0, overflow=0. Releasing button 0 produces no event until it re-arms.
